// File: rtl/target_port_pkg.sv
// Shared types and frame constants for the serial-to-target bridge port.
package target_port_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 5;

    // Frame bit counts: rw + address, plus data on writes (parity excluded).
    localparam int RD_FRAME_BITS = 1 + ADDR_W;
    localparam int WR_FRAME_BITS = 1 + ADDR_W + DATA_W;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        RX_PAR,
        ISSUE,
        WAIT_ACK,
        TX_DATA,
        DONE
    } state_t;

endpackage

// File: rtl/target_port_txser.sv
// Parallel-load MSB-first serializer returning target read data on the bus.
module target_port_txser
    import target_port_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              tx_bit,
    output logic              tx_valid,
    output logic              done
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            cnt   <= CW'(DATA_W);
        end else if (cnt != '0) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt - 1'b1;
        end
    end

    assign tx_valid = (cnt != '0);
    assign tx_bit   = shreg[DATA_W-1] & tx_valid;
    // High on the last of the valid cycles.
    assign done     = (cnt == CW'(1));

endmodule

// File: rtl/target_port.sv
// Serial frame receiver issuing single target accesses and returning reads.
// Optional even parity bit per frame: define TARGET_PORT_PARITY_EN.
module target_port
    import target_port_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_rx_bit,
    input  logic              bus_rx_valid,
    output logic              bus_tx_bit,
    output logic              bus_tx_valid,
    output logic              bus_ack,
    output logic              bus_err,
    output logic              port_busy,
    output logic [ADDR_W-1:0] tgt_addr,
    output logic              tgt_addr_valid,
    output logic [DATA_W-1:0] tgt_wdata,
    output logic              tgt_wdata_valid,
    output logic              tgt_rw,
    input  logic [DATA_W-1:0] tgt_rdata,
    input  logic              tgt_rdata_valid,
    input  logic              tgt_ack,
    input  logic              tgt_ready
);

    localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

`ifdef TARGET_PORT_PARITY_EN
    localparam state_t RX_END = RX_PAR;
`else
    localparam state_t RX_END = ISSUE;
`endif

    state_t state;
    state_t state_nx;

    logic [CNT_W-1:0]  bit_cnt;
    logic [TO_W-1:0]   wait_cnt;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_nx;
    logic              tx_load;
    logic              tx_done;
    logic [DATA_W-1:0] tx_data;
    logic              addr_last;
    logic              data_last;

`ifdef TARGET_PORT_PARITY_EN
    logic              par_q;
`endif

    assign addr_last = (bit_cnt == CNT_W'(RD_FRAME_BITS - 1));
    assign data_last = (bit_cnt == CNT_W'(WR_FRAME_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        tgt_addr_valid  = 1'b0;
        tgt_wdata_valid = 1'b0;
        tx_load         = 1'b0;
        err_nx          = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus_rx_valid) begin
                    state_nx = RX_ADDR;
                end
            end
            RX_ADDR: begin
                if (bus_rx_valid && addr_last) begin
                    state_nx = rw_q ? RX_DATA : RX_END;
                end
            end
            RX_DATA: begin
                if (bus_rx_valid && data_last) begin
                    state_nx = RX_END;
                end
            end
            RX_PAR: begin
`ifdef TARGET_PORT_PARITY_EN
                if (bus_rx_valid) begin
                    if (par_q ^ bus_rx_bit) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = ISSUE;
                    end
                end
`else
                state_nx = IDLE;
`endif
            end
            ISSUE: begin
                if (tgt_ready) begin
                    tgt_addr_valid  = 1'b1;
                    tgt_wdata_valid = rw_q;
                    state_nx        = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tgt_ack) begin
                    if (rw_q) begin
                        state_nx = DONE;
                    end else begin
                        tx_load  = 1'b1;
                        state_nx = TX_DATA;
                    end
                end else if (wait_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    // Last permitted cycle elapsed without an ack.
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            TX_DATA: begin
                if (tx_done) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            wait_cnt <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            bus_ack  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            bus_ack <= (state == DONE);
            bus_err <= err_nx;
            if (bus_rx_valid) begin
                if (state == IDLE) begin
                    rw_q    <= bus_rx_bit;
                    bit_cnt <= CNT_W'(1);
                end else if (state == RX_ADDR) begin
                    addr_q  <= {addr_q[ADDR_W-2:0], bus_rx_bit};
                    bit_cnt <= bit_cnt + 1'b1;
                end else if (state == RX_DATA) begin
                    wdata_q <= {wdata_q[DATA_W-2:0], bus_rx_bit};
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT_ACK) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == WAIT_ACK && tgt_rdata_valid) begin
                rdata_q <= tgt_rdata;
            end
        end
    end

`ifdef TARGET_PORT_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (bus_rx_valid) begin
            if (state == IDLE) begin
                par_q <= bus_rx_bit;
            end else if (state == RX_ADDR || state == RX_DATA) begin
                par_q <= par_q ^ bus_rx_bit;
            end
        end
    end
`endif

    // Data arriving with the ack is forwarded straight to the serializer.
    assign tx_data = tgt_rdata_valid ? tgt_rdata : rdata_q;

    target_port_txser u_txser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tx_load),
        .data     (tx_data),
        .tx_bit   (bus_tx_bit),
        .tx_valid (bus_tx_valid),
        .done     (tx_done)
    );

    assign port_busy = (state != IDLE);
    assign tgt_addr  = addr_q;
    assign tgt_wdata = wdata_q;
    assign tgt_rw    = rw_q;

endmodule

// File: tb/tb_target_port.sv
// Scoreboard bench for target_port: directed frames, monitor-side checking.
module tb_target_port;

    logic        clk;
    logic        rst_n;
    logic        bus_rx_bit;
    logic        bus_rx_valid;
    logic        bus_tx_bit;
    logic        bus_tx_valid;
    logic        bus_ack;
    logic        bus_err;
    logic        port_busy;
    logic [15:0] tgt_addr;
    logic        tgt_addr_valid;
    logic [7:0]  tgt_wdata;
    logic        tgt_wdata_valid;
    logic        tgt_rw;
    logic [7:0]  tgt_rdata;
    logic        tgt_rdata_valid;
    logic        tgt_ack;
    logic        tgt_ready;

    target_port #(.ACK_TIMEOUT(15)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus_rx_bit      (bus_rx_bit),
        .bus_rx_valid    (bus_rx_valid),
        .bus_tx_bit      (bus_tx_bit),
        .bus_tx_valid    (bus_tx_valid),
        .bus_ack         (bus_ack),
        .bus_err         (bus_err),
        .port_busy       (port_busy),
        .tgt_addr        (tgt_addr),
        .tgt_addr_valid  (tgt_addr_valid),
        .tgt_wdata       (tgt_wdata),
        .tgt_wdata_valid (tgt_wdata_valid),
        .tgt_rw          (tgt_rw),
        .tgt_rdata       (tgt_rdata),
        .tgt_rdata_valid (tgt_rdata_valid),
        .tgt_ack         (tgt_ack),
        .tgt_ready       (tgt_ready)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wr;
    } strobe_t;

    // ref_kind: 0 no latency check, 1 from tgt_ack, 2 from strobe
    typedef struct {
        logic is_err;
        int   ref_kind;
        int   lat;
    } resp_t;

    strobe_t strobe_q[$];
    logic    tx_q[$];
    resp_t   resp_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   resp_seen = 0;
    int   cyc = 0;
    int   ack_cyc = 0;
    int   strobe_cyc = 0;
    logic ack_en;
    logic [7:0] rd_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    task automatic exp_strobe(input logic [15:0] a, input logic [7:0] d,
                              input logic wr);
        strobe_t s;
        s.addr  = a;
        s.wdata = d;
        s.wr    = wr;
        strobe_q.push_back(s);
    endtask

    task automatic exp_resp(input logic e, input int k, input int l);
        resp_t r;
        r.is_err   = e;
        r.ref_kind = k;
        r.lat      = l;
        resp_q.push_back(r);
    endtask

    task automatic exp_tx(input logic [7:0] b);
        logic [7:0] v;
        v = b;
        for (int i = 7; i >= 0; i--) tx_q.push_back(v[i]);
    endtask

    // Called and returns at posedge+1.
    task automatic send_frame(input logic rw, input logic [15:0] a,
                              input logic [7:0] d, input int gap_at,
                              input int gap_len, input logic flip,
                              input int max_bits);
        logic bits[$];
        logic p;
        bits.push_back(rw);
        for (int i = 15; i >= 0; i--) bits.push_back(a[i]);
        if (rw) for (int i = 7; i >= 0; i--) bits.push_back(d[i]);
        p = flip;
`ifdef TARGET_PORT_PARITY_EN
        foreach (bits[i]) p = p ^ bits[i];
        bits.push_back(p);
`else
        if (p) $display("note: parity flip ignored in this build");
`endif
        for (int i = 0; i < bits.size() && i < max_bits; i++) begin
            if (i == gap_at) begin
                repeat (gap_len) begin
                    bus_rx_valid = 1'b0;
                    bus_rx_bit   = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            bus_rx_valid = 1'b1;
            bus_rx_bit   = bits[i];
            @(posedge clk); #1;
        end
        bus_rx_valid = 1'b0;
        bus_rx_bit   = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int t;
        t = 0;
        while (resp_seen < n && t < 300) begin
            @(negedge clk); #1;
            t++;
        end
        if (resp_seen < n) fail("resp_timeout", "no bus_ack/bus_err in time");
    endtask

    // Target model: acks the cycle after each strobe when enabled.
    initial begin : target
        tgt_ack         = 1'b0;
        tgt_rdata_valid = 1'b0;
        tgt_rdata       = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && tgt_addr_valid && ack_en) begin
                @(posedge clk); #1;
                tgt_ack         = 1'b1;
                tgt_rdata_valid = !tgt_rw;
                tgt_rdata       = tgt_rw ? 8'h00 : rd_val;
                ack_cyc         = cyc;
                @(posedge clk); #1;
                tgt_ack         = 1'b0;
                tgt_rdata_valid = 1'b0;
                tgt_rdata       = 8'h00;
            end
        end
    end

    initial begin : monitor
        strobe_t s;
        resp_t   r;
        logic    b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tgt_addr_valid) begin
                    strobe_cyc = cyc;
                    chk("strobe_while_ready", {31'd0, tgt_ready}, 32'd1);
                    if (strobe_q.size() == 0) begin
                        fail("unexpected_strobe", "tgt_addr_valid with none due");
                    end else begin
                        s = strobe_q.pop_front();
                        chk("tgt_addr", {16'd0, tgt_addr}, {16'd0, s.addr});
                        chk("tgt_rw", {31'd0, tgt_rw}, {31'd0, s.wr});
                        chk("tgt_wdata_valid", {31'd0, tgt_wdata_valid},
                            {31'd0, s.wr});
                        if (s.wr) chk("tgt_wdata", {24'd0, tgt_wdata},
                                      {24'd0, s.wdata});
                    end
                end
                if (bus_tx_valid) begin
                    if (tx_q.size() == 0) begin
                        fail("unexpected_tx", "bus_tx_valid with none due");
                    end else begin
                        b = tx_q.pop_front();
                        chk("bus_tx_bit", {31'd0, bus_tx_bit}, {31'd0, b});
                    end
                end
                if (bus_ack || bus_err) begin
                    resp_seen++;
                    if (resp_q.size() == 0) begin
                        fail("unexpected_resp", "bus_ack/bus_err with none due");
                    end else begin
                        r = resp_q.pop_front();
                        chk("resp_kind", {30'd0, bus_err, bus_ack},
                            r.is_err ? 32'd2 : 32'd1);
                        if (r.ref_kind == 1)
                            chk("ack_latency", cyc - ack_cyc, r.lat);
                        if (r.ref_kind == 2)
                            chk("err_latency", cyc - strobe_cyc, r.lat);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n        = 1'b0;
        bus_rx_bit   = 1'b0;
        bus_rx_valid = 1'b0;
        tgt_ready    = 1'b1;
        ack_en       = 1'b1;
        rd_val       = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_port_busy", {31'd0, port_busy}, 32'd0);
        chk("rst_bus_ack", {31'd0, bus_ack}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_tx_valid", {31'd0, bus_tx_valid}, 32'd0);
        chk("rst_tgt_addr", {16'd0, tgt_addr}, 32'd0);
        chk("rst_tgt_wdata", {24'd0, tgt_wdata}, 32'd0);
        chk("rst_addr_valid", {31'd0, tgt_addr_valid}, 32'd0);
        chk("rst_tgt_rw", {31'd0, tgt_rw}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write 0x0012 <- 0xA5, bus_ack two cycles after tgt_ack.
        exp_strobe(16'h0012, 8'hA5, 1'b1);
        exp_resp(1'b0, 1, 2);
        send_frame(1'b1, 16'h0012, 8'hA5, -1, 0, 1'b0, 99);
        wait_resp(1);

        // Back-to-back read of 0x0012 returning 0x3C.
        @(posedge clk); #1;
        rd_val = 8'h3C;
        exp_strobe(16'h0012, 8'h00, 1'b0);
        tx_q.push_back(1'b0); tx_q.push_back(1'b0);
        tx_q.push_back(1'b1); tx_q.push_back(1'b1);
        tx_q.push_back(1'b1); tx_q.push_back(1'b1);
        tx_q.push_back(1'b0); tx_q.push_back(1'b0);
        exp_resp(1'b0, 1, 10);
        send_frame(1'b0, 16'h0012, 8'h00, -1, 0, 1'b0, 99);
        wait_resp(2);

        // Five-cycle rx_valid gap in the middle of the address.
        repeat (2) @(posedge clk); #1;
        exp_strobe(16'hBEEF, 8'h5A, 1'b1);
        exp_resp(1'b0, 1, 2);
        send_frame(1'b1, 16'hBEEF, 8'h5A, 8, 5, 1'b0, 99);
        wait_resp(3);

        // Read with alternating end bits.
        repeat (2) @(posedge clk); #1;
        rd_val = 8'h81;
        exp_strobe(16'h7E01, 8'h00, 1'b0);
        exp_tx(8'h81);
        exp_resp(1'b0, 1, 10);
        send_frame(1'b0, 16'h7E01, 8'h00, -1, 0, 1'b0, 99);
        wait_resp(4);

        // Target not ready for 10 cycles, then never acks.
        repeat (2) @(posedge clk); #1;
        tgt_ready = 1'b0;
        ack_en    = 1'b0;
        exp_strobe(16'h00C3, 8'h00, 1'b0);
        exp_resp(1'b1, 2, 16);
        send_frame(1'b0, 16'h00C3, 8'h00, -1, 0, 1'b0, 99);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_strobe_unready", {31'd0, tgt_addr_valid}, 32'd0);
        end
        chk("busy_in_issue", {31'd0, port_busy}, 32'd1);
        @(posedge clk); #1;
        tgt_ready = 1'b1;
        wait_resp(5);
        @(negedge clk);
        chk("idle_after_timeout", {31'd0, port_busy}, 32'd0);
        ack_en = 1'b1;

        // Reset during write data, then a clean write.
        @(posedge clk); #1;
        send_frame(1'b1, 16'h1234, 8'h99, -1, 0, 1'b0, 21);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, port_busy}, 32'd0);
        chk("abort_addr", {16'd0, tgt_addr}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        exp_strobe(16'h0F0F, 8'hC3, 1'b1);
        exp_resp(1'b0, 1, 2);
        send_frame(1'b1, 16'h0F0F, 8'hC3, -1, 0, 1'b0, 99);
        wait_resp(6);

`ifdef TARGET_PORT_PARITY_EN
        // Corrupted parity: error, no access.
        repeat (2) @(posedge clk); #1;
        exp_resp(1'b1, 0, 0);
        send_frame(1'b1, 16'h4321, 8'h77, -1, 0, 1'b1, 99);
        wait_resp(7);
`endif

        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("strobe_q_drained", strobe_q.size(), 32'd0);
        chk("tx_q_drained", tx_q.size(), 32'd0);
        chk("resp_q_drained", resp_q.size(), 32'd0);
        chk("final_idle", {31'd0, port_busy}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
